// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong bit-reversal reorder buffer for the FFT datapath.
// Natural-order frames of 2^k words (k sampled on the first word, clamped to
// KMIN..KMAX) are written into one bank while the other bank is read out in
// bit-reversed or natural order. Both sides support back-pressure.
//
// Optional feature macro: BITREV_REORDER_LAST_CHK_EN
//   defined   -> err_o is a sticky flag raised when last_i disagrees with
//                the word count of the frame being written.
//   undefined -> err_o is tied low and last_i is ignored.

module bitrev_reorder #(
  parameter int KMAX = 10,
  parameter int KMIN = 2,
  parameter int DW   = 32,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic [KW-1:0] size_i,
  input  logic          rev_en_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic          err_o
);

  localparam int DEPTH = 1 << KMAX;

  typedef logic [KMAX-1:0] cnt_t;
  typedef logic [KW-1:0]   k_t;

  // Clamp a requested log2 size into the legal KMIN..KMAX range.
  function automatic k_t clamp_k(input k_t s);
    if (int'(s) < KMIN) return k_t'(KMIN);
    if (int'(s) > KMAX) return k_t'(KMAX);
    return s;
  endfunction

  // Index of the final word of a 2^k frame, i.e. 2^k - 1.
  function automatic cnt_t frame_mask(input k_t k);
    cnt_t m;
    m = '0;
    for (int i = 0; i < KMAX; i++) m[i] = (i < int'(k));
    return m;
  endfunction

  // Reverse the low k bits of cnt across k bits; upper bits come out zero.
  function automatic cnt_t bit_rev(input cnt_t cnt, input k_t k);
    cnt_t r;
    r = '0;
    for (int i = 0; i < KMAX; i++) begin
      for (int j = 0; j < KMAX; j++) begin
        if (i + j + 1 == int'(k)) r[i] = cnt[j];
      end
    end
    return r;
  endfunction

  // Storage and per-bank bookkeeping
  logic [DW-1:0] mem [2*DEPTH];
  logic          wr_bank, rd_bank;
  logic [1:0]    full;
  cnt_t          wr_cnt, rd_cnt;
  k_t            kb [2];
  logic [1:0]    revb;

  // Decoded control
  logic accept, wr_first, wr_last, rd_adv, rd_last;
  k_t   k_in, wr_k, rd_k;
  cnt_t rd_addr;

  assign ready_o = !full[wr_bank];

  // Writer/reader decode: frame boundaries, handshakes and the read address.
  // NOTE: every signal here is assigned on every pass through the block, so
  // no storage is implied and no latch can be inferred.
  always_comb begin
    k_in     = clamp_k(size_i);
    wr_first = (wr_cnt == '0);
    wr_k     = wr_first ? k_in : kb[wr_bank];
    accept   = valid_i && ready_o;
    wr_last  = (wr_cnt == frame_mask(wr_k));
    rd_k     = kb[rd_bank];
    rd_last  = (rd_cnt == frame_mask(rd_k));
    rd_adv   = full[rd_bank] && (ready_i || !valid_o);
    rd_addr  = revb[rd_bank] ? bit_rev(rd_cnt, rd_k) : rd_cnt;
  end

  // Bank write port.
  // NOTE: the array itself is not reset; a reset clears the full flags and
  // counters, which is enough to make any stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (accept) mem[{wr_bank, wr_cnt}] <= data_i;
  end

  // Writer: word counter, bank select and per-frame size/mode capture.
  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      kb[0]   <= k_t'(KMAX);
      kb[1]   <= k_t'(KMAX);
      revb    <= 2'b11;
    end else if (accept) begin
      if (wr_first) begin
        kb[wr_bank]   <= k_in;
        revb[wr_bank] <= rev_en_i;
      end
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + cnt_t'(1);
      end
    end
  end

  // Bank full flags: set by the writer on a frame's final word, cleared by
  // the reader when it loads that bank's final word. Both never hit the same
  // bank on one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= '0;
    end else begin
      if (rd_adv && rd_last) full[rd_bank] <= 1'b0;
      if (accept && wr_last) full[wr_bank] <= 1'b1;
    end
  end

  // Reader: registered output stage fed by the combinational bank read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (rd_adv) begin
      data_o  <= mem[{rd_bank, rd_addr}];
      valid_o <= 1'b1;
      last_o  <= rd_last;
      if (rd_last) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + cnt_t'(1);
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef BITREV_REORDER_LAST_CHK_EN
  logic err_q;

  // Sticky framing check: last_i must mark exactly the count-defined end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept && (last_i != wr_last)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  // Framing is purely count-based; last_i is only consumed by the checker.
  logic unused_last;
  assign unused_last = last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// tb_bitrev_reorder: scoreboard bench for bitrev_reorder. Frames are built
// from random or sequential data; the expected output order is computed from
// the bit-reversal rule and queued, and a monitor pops and compares on every
// output transfer.

module tb_bitrev_reorder;

  localparam int KMAX = 10;
  localparam int KMIN = 2;
  localparam int DW   = 32;
  localparam int KW   = $clog2(KMAX + 1);

`ifdef BITREV_REORDER_LAST_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk_i;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          last_i;
  logic [KW-1:0] size_i;
  logic          rev_en_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          err_o;

  bitrev_reorder #(
    .KMAX(KMAX),
    .KMIN(KMIN),
    .DW  (DW),
    .KW  (KW)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .size_i  (size_i),
    .rev_en_i(rev_en_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fbuf [1 << KMAX];

  int   tests = 0;
  int   fails = 0;
  int   acc_cnt = 0;   // input accepts, counted by the monitor
  int   gap_cnt = 0;   // output bubbles right after a transfer with data pending
  bit   rdy_rand = 1'b0;
  bit   sender_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rules: clamp of the requested size and k-bit index reversal.
  function automatic int kclamp(input int s);
    if (s < KMIN) return KMIN;
    if (s > KMAX) return KMAX;
    return s;
  endfunction

  function automatic int brev(input int j, input int k);
    int r = 0;
    for (int b = 0; b < k; b++) r = r * 2 + ((j >> b) & 1);
    return r;
  endfunction

  task automatic push_expected(input int k, input bit rev);
    exp_t e;
    int   n = 1 << k;
    for (int j = 0; j < n; j++) begin
      e.data = rev ? fbuf[brev(j, k)] : fbuf[j];
      e.last = (j == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Present one word (entered just after a rising edge) until accepted.
  task automatic drive_word(input logic [DW-1:0] d, input logic l, input logic [KW-1:0] s,
                            input logic r, output int waits);
    bit acc = 1'b0;
    int budget = 5000;
    valid_i  = 1'b1;
    data_i   = d;
    last_i   = l;
    size_i   = s;
    rev_en_i = r;
    waits    = 0;
    while (!acc && budget > 0) begin
      @(negedge clk_i);
      acc = ready_o;
      sync();
      if (!acc) waits++;
      budget--;
    end
    valid_i = 1'b0;
    if (!acc) check("wr_accept_timeout", 64'(acc), 64'(1));
  endtask

  // Send one frame; size_i/rev_en_i carry junk after the first word.
  task automatic send_frame(input int size, input bit rev, input int base, input int gap_pct,
                            output int stalls);
    int k = kclamp(size);
    int n = 1 << k;
    int w;
    for (int i = 0; i < n; i++) fbuf[i] = (base < 0) ? DW'($urandom) : DW'(base + i);
    push_expected(k, rev);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) sync();
      drive_word(fbuf[i], (i == n - 1), (i == 0) ? KW'(size) : KW'($urandom_range(15)),
                 (i == 0) ? rev : 1'($urandom_range(1)), w);
      stalls += w;
    end
  endtask

  task automatic wait_drain(input int budget);
    while ((exp_q.size() != 0 || sender_busy) && budget > 0) begin
      sync();
      budget--;
    end
    if (exp_q.size() != 0) check("drain_left", 64'(exp_q.size()), 64'(0));
    repeat (3) sync();
  endtask

  // Output monitor: scoreboard pops, hold-stability and bubble accounting.
  bit            stall_prev = 1'b0;
  bit            pop_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  exp_t          mon_e;

  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_prev = 1'b0;
      pop_prev   = 1'b0;
    end else begin
      if (valid_i && ready_o) acc_cnt++;
      if (stall_prev) begin
        check("hold_data", 64'(data_o), 64'(held_data));
        check("hold_last", 64'(last_o), 64'(held_last));
      end
      if (!valid_o && pop_prev && exp_q.size() != 0) gap_cnt++;
      pop_prev = 1'b0;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(valid_o), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(data_o), 64'(mon_e.data));
          check("out_last", 64'(last_o), 64'(mon_e.last));
          pop_prev = 1'b1;
        end
      end
      stall_prev = valid_o && !ready_i;
      held_data  = data_o;
      held_last  = last_o;
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      sync();
      if (rdy_rand) ready_i = ($urandom_range(99) < 65);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s1, s2, w, g0, a0;
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; last_i = 1'b0;
    size_i = '0; rev_en_i = 1'b0; ready_i = 1'b1;
    repeat (2) sync();
    rst_i = 1'b0;

    // Partial frame, then reset: must leave no trace.
    for (int i = 0; i < 3; i++) drive_word(DW'(32'hdead0000 + i), 1'b0, KW'(3), 1'b1, w);
    rst_i = 1'b1;
    repeat (2) sync();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready_o", 64'(ready_o), 64'(1));
    check("rst_valid_o", 64'(valid_o), 64'(0));
    check("rst_data_o",  64'(data_o),  64'(0));
    check("rst_last_o",  64'(last_o),  64'(0));
    check("rst_err_o",   64'(err_o),   64'(0));
    sync();

    // k=3 bit-reverse of 0..7 and first-word latency.
    send_frame(3, 1'b1, 0, 0, s1);
    @(negedge clk_i);
    check("lat_valid_low", 64'(valid_o), 64'(0));
    sync();
    check("lat_valid_high", 64'(valid_o), 64'(1));
    check("lat_first_data", 64'(data_o), 64'(0));
    wait_drain(200);

    // Natural k=2 pass, then k=4 reversed: input never stalls.
    send_frame(2, 1'b0, 10, 0, s1);
    send_frame(4, 1'b1, 0, 0, s2);
    check("switch_in_stalls", 64'(s1 + s2), 64'(0));
    wait_drain(200);

    // Equal sizes back to back: no output bubble.
    g0 = gap_cnt;
    send_frame(3, 1'b1, -1, 0, s1);
    send_frame(3, 1'b1, -1, 0, s2);
    check("equal_in_stalls", 64'(s1 + s2), 64'(0));
    wait_drain(200);
    check("equal_out_gaps", 64'(gap_cnt - g0), 64'(0));

    // Back-pressure fill: three k=2 frames with the consumer stalled.
    ready_i = 1'b0;
    a0 = acc_cnt;
    sender_busy = 1'b1;
    fork
      begin : bp_sender
        int sb;
        for (int f = 0; f < 3; f++) send_frame(2, 1'b1, -1, 0, sb);
        sender_busy = 1'b0;
      end
    join_none
    for (int c = 0; c < 100 && (acc_cnt - a0) < 8; c++) sync();
    check("bp_accepts", 64'(acc_cnt - a0), 64'(8));
    check("bp_ready_low", 64'(ready_o), 64'(0));
    check("bp_first_loaded", 64'(valid_o), 64'(1));
    repeat (3) sync();
    check("bp_ready_hold", 64'(ready_o), 64'(0));
    ready_i = 1'b1;
    sync();
    check("bp_rel_load2", 64'(ready_o), 64'(0));
    sync();
    check("bp_rel_load3", 64'(ready_o), 64'(0));
    sync();
    check("bp_rel_load4", 64'(ready_o), 64'(1));
    check("bp_rel_last", 64'(last_o), 64'(1));
    wait_drain(500);

    // Random valid/ready at k=5, then random sizes including clamped ones.
    rdy_rand = 1'b1;
    for (int f = 0; f < 16; f++) send_frame(5, 1'($urandom_range(1)), -1, 30, s1);
    for (int f = 0; f < 8; f++) send_frame($urandom_range(6), 1'($urandom_range(1)), -1, 30, s1);
    wait_drain(20000);
    rdy_rand = 1'b0;
    sync();
    ready_i = 1'b1;

    // Oversized request clamps to KMAX.
    send_frame(15, 1'b1, -1, 0, s1);
    wait_drain(5000);

    // Framing check: last_i asserted early on word 5 of a k=3 frame.
    check("err_clean", 64'(err_o), 64'(0));
    for (int i = 0; i < 8; i++) fbuf[i] = DW'($urandom);
    push_expected(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_word(fbuf[i], (i == 5) || (i == 7), (i == 0) ? KW'(3) : KW'($urandom_range(15)),
                 (i == 0) ? 1'b1 : 1'($urandom_range(1)), w);
      if (i == 4) check("err_before", 64'(err_o), 64'(0));
      if (i == 5) check("err_set", 64'(err_o), 64'(EXP_ERR));
    end
    wait_drain(200);
    check("err_held", 64'(err_o), 64'(EXP_ERR));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
